// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard sequencer: drains scan-code bytes from the ps2_kbd receiver
// FIFO, folds E0/F0 prefixes into {brk, ext, code} key events and queues them
// for the CPU.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | wait for a byte in ps2_kbd and room in the event queue
// POP    | kbd_rdn low for this one cycle; byte latched at its end
// DECODE | fold prefix into flags, or push the completed key event
module ps2_kbd_ctrl #(
    parameter int EVQ_AW    = 2,
    parameter int EVQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              kbd_ready,
    input  logic [7:0]        kbd_data,
    input  logic              kbd_overflow,
    output logic              kbd_rdn,
    output logic              ev_valid,
    output logic [9:0]        ev_data,
    input  logic              ev_ack,
    output logic [EVQ_AW:0]   ev_count,
    output logic              ovf_sticky,
    input  logic              clr_ovf
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_POP    = 2'd1,
        S_DECODE = 2'd2
    } state_t;

    localparam logic [EVQ_AW:0] DEPTH_C = (EVQ_AW + 1)'(EVQ_DEPTH);

    state_t              state_q, state_d;
    logic                rdn_q;
    logic [7:0]          byte_q;
    logic                brk_q, brk_d;
    logic                ext_q, ext_d;
    logic                push, pop;
    logic [9:0]          mem_q [EVQ_DEPTH];
    logic [EVQ_AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [EVQ_AW:0]     count_q;
    logic                ovf_q;

    // Next-state and prefix-flag decode; a push only happens for non-prefix bytes.
    always_comb begin
        state_d = state_q;
        brk_d   = brk_q;
        ext_d   = ext_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Holding here while full leaves bytes in ps2_kbd, so nothing is dropped.
                if (kbd_ready && (count_q < DEPTH_C)) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (byte_q == 8'hE0) begin
                    ext_d = 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_d = 1'b1;
                end else begin
                    push  = 1'b1;
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pop = ev_ack && (count_q != '0);

    // Sequencer registers; kbd_rdn is registered from the next state so it is low exactly in POP.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= S_IDLE;
            rdn_q   <= 1'b1;
            byte_q  <= 8'h00;
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdn_q   <= (state_d != S_POP);
            brk_q   <= brk_d;
            ext_q   <= ext_d;
            if (state_q == S_POP) begin
                byte_q <= kbd_data;
            end
        end
    end

    // Event queue storage, pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < EVQ_DEPTH; i++) begin
                mem_q[i] <= 10'h000;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {brk_q, ext_q, byte_q};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow flag; a new overflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ovf_q <= 1'b0;
        end else if (kbd_overflow) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    assign kbd_rdn    = rdn_q;
    assign ev_valid   = (count_q != '0);
    assign ev_data    = (count_q != '0) ? mem_q[rd_ptr_q] : 10'h000;
    assign ev_count   = count_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: a byte-queue stand-in for the ps2_kbd FIFO plus a
// scan-code-to-event reference model, with directed and random traffic.
module tb_ps2_kbd_ctrl;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       kbd_ready = 1'b0;
    logic [7:0] kbd_data = 8'h00;
    logic       kbd_overflow = 1'b0;
    logic       kbd_rdn;
    logic       ev_valid;
    logic [9:0] ev_data;
    logic       ev_ack = 1'b0;
    logic [2:0] ev_count;
    logic       ovf_sticky;
    logic       clr_ovf = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [7:0] src_q [$];
    logic [9:0] exp_q [$];
    logic       m_brk = 1'b0;
    logic       m_ext = 1'b0;
    logic       pend  = 1'b0;

    ps2_kbd_ctrl #(.EVQ_AW(2), .EVQ_DEPTH(4)) dut (
        .clk          (clk),
        .clrn         (clrn),
        .kbd_ready    (kbd_ready),
        .kbd_data     (kbd_data),
        .kbd_overflow (kbd_overflow),
        .kbd_rdn      (kbd_rdn),
        .ev_valid     (ev_valid),
        .ev_data      (ev_data),
        .ev_ack       (ev_ack),
        .ev_count     (ev_count),
        .ovf_sticky   (ovf_sticky),
        .clr_ovf      (clr_ovf)
    );

    always #5 clk = ~clk;

    // The source FIFO pops when the pop strobe is seen low mid-cycle.
    always @(negedge clk) pend = !kbd_rdn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: a key event is the code byte tagged with the prefixes seen since the last event.
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            exp_q.push_back({m_brk, m_ext, b});
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_brk = 1'b0;
        m_ext = 1'b0;
        exp_q.delete();
    endtask

    task automatic refresh_src();
        kbd_ready = (src_q.size() != 0);
        kbd_data  = kbd_ready ? src_q[0] : 8'h00;
    endtask

    task automatic feed(input logic [7:0] b);
        src_q.push_back(b);
        refresh_src();
    endtask

    // One clock: check any accepted pop against the model, then advance the source FIFO.
    task automatic tick();
        logic [9:0] e;
        if (ev_ack && ev_valid) begin
            if (exp_q.size() == 0) check("spurious_event", 32'(ev_data), 32'h400);
            else begin
                e = exp_q.pop_front();
                check("head", 32'(ev_data), 32'(e));
            end
        end
        @(posedge clk);
        #1;
        if (pend && src_q.size() != 0) model_byte(src_q.pop_front());
        refresh_src();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_one(input string tag, input logic [9:0] exp);
        check(tag, 32'(ev_data), 32'(exp));
        ev_ack = 1'b1;
        tick();
        ev_ack = 1'b0;
    endtask

    task automatic wait_rdn_low(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (kbd_rdn == 1'b0) break;
            tick();
        end
        check(tag, 32'(kbd_rdn), 32'h0);
    endtask

    logic [7:0] special [5] = '{8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'h00};

    initial begin
        // Reset with data already waiting
        feed(8'h1C);
        ticks(2);
        check("rst_rdn", 32'(kbd_rdn), 32'h1);
        check("rst_valid", 32'(ev_valid), 32'h0);
        check("rst_count", 32'(ev_count), 32'h0);
        check("rst_data", 32'(ev_data), 32'h0);
        check("rst_ovf", 32'(ovf_sticky), 32'h0);
        clrn = 1'b1;
        tick();
        check("pop_rdn_low", 32'(kbd_rdn), 32'h0);
        tick();
        check("pop_rdn_high", 32'(kbd_rdn), 32'h1);
        check("lat_not_yet", 32'(ev_valid), 32'h0);
        tick();
        check("lat_valid", 32'(ev_valid), 32'h1);
        check("lat_count", 32'(ev_count), 32'h1);
        expect_one("ev_1c", 10'h01C);

        // Prefix folding
        feed(8'hF0); feed(8'h1C);
        ticks(8);
        expect_one("ev_f0_1c", 10'h21C);
        feed(8'hE0); feed(8'hF0); feed(8'h75);
        ticks(11);
        expect_one("ev_e0_f0_75", 10'h375);
        feed(8'hF0); feed(8'hE0); feed(8'h75);
        ticks(11);
        expect_one("ev_f0_e0_75", 10'h375);
        feed(8'hE0); feed(8'hE0); feed(8'hAA);
        ticks(11);
        expect_one("ev_e0_e0_aa", 10'h1AA);

        // Full queue back-pressure
        for (int i = 1; i <= 6; i++) feed(8'(i));
        ticks(30);
        check("full_count", 32'(ev_count), 32'h4);
        check("full_src_left", 32'(src_q.size()), 32'h2);
        for (int i = 0; i < 5; i++) begin
            check("full_rdn_hold", 32'(kbd_rdn), 32'h1);
            tick();
        end
        expect_one("full_ev1", 10'h001);
        expect_one("full_ev2", 10'h002);
        expect_one("full_ev3", 10'h003);
        expect_one("full_ev4", 10'h004);
        ticks(10);
        expect_one("full_ev5", 10'h005);
        ticks(4);
        expect_one("full_ev6", 10'h006);
        ticks(2);
        check("full_empty", 32'(ev_count), 32'h0);

        // Push and pop in the same cycle
        feed(8'h11); feed(8'h12);
        ticks(10);
        check("pp_pre_count", 32'(ev_count), 32'h2);
        feed(8'h13);
        wait_rdn_low("pp_pop_seen");
        tick();
        ev_ack = 1'b1;
        tick();
        ev_ack = 1'b0;
        check("pp_count", 32'(ev_count), 32'h2);
        expect_one("pp_ev12", 10'h012);
        expect_one("pp_ev13", 10'h013);

        // Pop with empty queue is ignored
        ev_ack = 1'b1;
        ticks(2);
        ev_ack = 1'b0;
        check("empty_ack_count", 32'(ev_count), 32'h0);
        check("empty_ack_valid", 32'(ev_valid), 32'h0);
        check("empty_ack_data", 32'(ev_data), 32'h0);

        // Overflow flag
        kbd_overflow = 1'b1;
        tick();
        kbd_overflow = 1'b0;
        check("ovf_set", 32'(ovf_sticky), 32'h1);
        ticks(3);
        check("ovf_hold", 32'(ovf_sticky), 32'h1);
        clr_ovf = 1'b1;
        kbd_overflow = 1'b1;
        tick();
        check("ovf_set_wins", 32'(ovf_sticky), 32'h1);
        kbd_overflow = 1'b0;
        tick();
        check("ovf_clr", 32'(ovf_sticky), 32'h0);
        clr_ovf = 1'b0;

        // Reset during POP drops the pending break prefix
        feed(8'hF0);
        ticks(4);
        feed(8'h1C);
        wait_rdn_low("rst_pop_seen");
        #1;
        clrn = 1'b0;
        #1;
        check("rst_async_rdn", 32'(kbd_rdn), 32'h1);
        check("rst_async_count", 32'(ev_count), 32'h0);
        model_reset();
        tick();
        clrn = 1'b1;
        ticks(4);
        expect_one("rst_flags_clear", 10'h01C);

        // Random traffic against the model
        for (int it = 0; it < 400; it++) begin
            if (src_q.size() < 4 && $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 9))
                    0:       feed(8'hE0);
                    1:       feed(8'hF0);
                    2:       feed(special[$urandom_range(0, 4)]);
                    default: feed(8'($urandom));
                endcase
            end
            ev_ack = 1'($urandom_range(0, 1));
            tick();
        end
        for (int i = 0; i < 300; i++) begin
            if (src_q.size() == 0 && exp_q.size() == 0 && !ev_valid) break;
            ev_ack = ev_valid;
            tick();
        end
        ev_ack = 1'b0;
        ticks(2);
        check("rand_model_left", 32'(exp_q.size()), 32'h0);
        check("rand_src_left", 32'(src_q.size()), 32'h0);
        check("rand_count_end", 32'(ev_count), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
